// File: rtl/pdec_fifo_pkg.sv
// Shared constants and helpers for the pdec single-port FIFO controller.
// The localparams describe the default configuration; modules derive their own
// sizes from their parameters so non-default instances stay consistent.
package pdec_fifo_pkg;

   localparam int unsigned DEF_DW       = 16;
   localparam int unsigned DEF_AW       = 8;
   localparam int unsigned DEF_SRAM_DLY = 2;
   localparam int unsigned DEF_AF_LVL   = 240;

   localparam int unsigned DEPTH = 2 ** DEF_AW;
   localparam int unsigned OB    = DEF_SRAM_DLY + 1;
   localparam int unsigned PTR_W = DEF_AW + 1;
   localparam int unsigned LVL_W = DEF_AW + 2;

   // Number of set bits in a 32-bit vector (callers zero-extend narrower vectors).
   function automatic int unsigned f_popcnt(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         n += 32'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/pdec_sp_fifo_ctrl_if.sv
// Push/pop valid-ready bus of the pdec FIFO controller.
// master: producer/consumer side; slave: the FIFO controller.
interface pdec_sp_fifo_ctrl_if
   import pdec_fifo_pkg::*;
#(
   parameter int unsigned DW = DEF_DW
);

   logic          wr_valid;
   logic          wr_ready;
   logic [DW-1:0] wr_data;
   logic          rd_valid;
   logic          rd_ready;
   logic [DW-1:0] rd_data;

   modport master (
      output wr_valid, wr_data, rd_ready,
      input  wr_ready, rd_valid, rd_data
   );

   modport slave (
      input  wr_valid, wr_data, rd_ready,
      output wr_ready, rd_valid, rd_data
   );

endinterface

// File: rtl/pdec_fifo_obuf.sv
// Small register-based first-word-fall-through buffer that absorbs SRAM read data.
// Capture and pop may happen in the same cycle, also when the buffer is full:
// the head slot is vacated and the new word becomes the tail.
module pdec_fifo_obuf
   import pdec_fifo_pkg::*;
#(
   parameter  int unsigned DW      = DEF_DW,
   parameter  int unsigned ENTRIES = OB,
   localparam int unsigned CW      = $clog2(ENTRIES + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic          valid,
   output logic [DW-1:0] head,
   output logic [CW-1:0] ob_cnt
);

   localparam int unsigned IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   logic [DW-1:0] mem_q [ENTRIES];
   logic [IW-1:0] wr_idx_q;
   logic [IW-1:0] rd_idx_q;
   logic [CW-1:0] cnt_q;

   // Entry count is not a power of two, so indices wrap explicitly.
   function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] i);
      return (i == IW'(ENTRIES - 1)) ? '0 : i + IW'(1);
   endfunction

   // Storage, indices and occupancy; flush drops all entries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            mem_q[i] <= '0;
         end
         wr_idx_q <= '0;
         rd_idx_q <= '0;
         cnt_q    <= '0;
      end else if (flush) begin
         wr_idx_q <= '0;
         rd_idx_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            mem_q[wr_idx_q] <= push_data;
            wr_idx_q        <= f_inc(wr_idx_q);
         end
         if (pop) begin
            rd_idx_q <= f_inc(rd_idx_q);
         end
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
   end

   assign valid  = (cnt_q != '0);
   assign head   = mem_q[rd_idx_q];
   assign ob_cnt = cnt_q;

endmodule

// File: rtl/pdec_sp_fifo_ctrl.sv
// Synchronous FIFO controller sequencing the banked single-port RAM wrapper (pdec_dp2sp).
// Continuous write/read pointers, read credits and an output buffer hide SRAM read latency
// so push and pop both run at one word per cycle.
// Optional status outputs (hwm, ovf_cnt) are built when PDEC_FIFO_STAT_EN is defined.
module pdec_sp_fifo_ctrl
   import pdec_fifo_pkg::*;
#(
   parameter  int unsigned DW       = DEF_DW,
   parameter  int unsigned AW       = DEF_AW,
   parameter  int unsigned SRAM_DLY = DEF_SRAM_DLY,
   parameter  int unsigned AF_LVL   = DEF_AF_LVL,
   localparam int unsigned LvlW     = AW + 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   pdec_sp_fifo_ctrl_if.slave  bus,
   output logic [LvlW-1:0]     level,
   output logic                almost_full,
   output logic                dpram_wen,
   output logic [AW-1:0]       dpram_waddr,
   output logic [DW-1:0]       dpram_wdata,
   output logic                dpram_ren,
   output logic [AW-1:0]       dpram_raddr,
   input  logic [DW-1:0]       dpram_rdata
`ifdef PDEC_FIFO_STAT_EN
   ,
   output logic [LvlW-1:0]     hwm,
   output logic [15:0]         ovf_cnt
`endif
);

   localparam int unsigned Depth = 2 ** AW;
   localparam int unsigned ObN   = SRAM_DLY + 1;
   localparam int unsigned PtrW  = AW + 1;
   localparam int unsigned CntW  = $clog2(ObN + 1);

   logic [PtrW-1:0]     wptr_q;
   logic [PtrW-1:0]     rptr_q;
   logic [PtrW-1:0]     wptr_vis_q;
   logic [SRAM_DLY-1:0] vpipe_q;
   logic [LvlW-1:0]     level_q;
   logic [LvlW-1:0]     level_d;

   logic                full;
   logic                push;
   logic                pop;
   logic                ren;
   logic                ob_push;
   logic                ob_valid;
   logic [DW-1:0]       ob_head;
   logic [CntW-1:0]     ob_cnt;
   int unsigned         credit_used;

   assign full         = ((wptr_q - rptr_q) == PtrW'(Depth));
   assign bus.wr_ready = !full && !flush;
   assign push         = bus.wr_valid && bus.wr_ready;
   assign pop          = ob_valid && bus.rd_ready && !flush;
   assign ob_push      = vpipe_q[SRAM_DLY-1] && !flush;

   assign bus.rd_valid = ob_valid;
   assign bus.rd_data  = ob_head;

   assign dpram_wen    = push;
   assign dpram_waddr  = wptr_q[AW-1:0];
   assign dpram_wdata  = bus.wr_data;
   assign dpram_ren    = ren;
   assign dpram_raddr  = rptr_q[AW-1:0];

   assign level        = level_q;
   assign almost_full  = (level_q >= LvlW'(AF_LVL));

   // Read issue: a word is readable once wptr_vis has passed it, and only while a buffer
   // slot is guaranteed at capture time. A word popped this cycle frees its slot, which
   // keeps the read stream at one word per cycle.
   always_comb begin
      credit_used = f_popcnt(32'(vpipe_q)) + 32'(ob_cnt);
      ren         = (rptr_q != wptr_vis_q) && (credit_used < ObN + 32'(pop)) && !flush;
   end

   // Next fill level: words pushed and not yet popped, wherever they currently live.
   always_comb begin
      level_d = level_q;
      if (flush) begin
         level_d = '0;
      end else begin
         level_d = level_q + LvlW'(push) - LvlW'(pop);
      end
   end

   // Pointers, visible write pointer, read-valid pipe and level.
   // wptr_vis trails wptr_q by one cycle, so a word written in cycle t is first read in
   // t+2, after any bank-conflict deferral inside the wrapper has landed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         wptr_vis_q <= '0;
         vpipe_q    <= '0;
         level_q    <= '0;
      end else if (flush) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         wptr_vis_q <= '0;
         vpipe_q    <= '0;
         level_q    <= '0;
      end else begin
         if (push) begin
            wptr_q <= wptr_q + PtrW'(1);
         end
         if (ren) begin
            rptr_q <= rptr_q + PtrW'(1);
         end
         wptr_vis_q <= wptr_q;
         vpipe_q    <= {vpipe_q[SRAM_DLY-2:0], ren};
         level_q    <= level_d;
      end
   end

   pdec_fifo_obuf #(
      .DW      (DW),
      .ENTRIES (ObN)
   ) u_obuf (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (ob_push),
      .push_data (dpram_rdata),
      .pop       (pop),
      .valid     (ob_valid),
      .head      (ob_head),
      .ob_cnt    (ob_cnt)
   );

`ifdef PDEC_FIFO_STAT_EN
   logic [LvlW-1:0] hwm_q;
   logic [15:0]     ovf_cnt_q;

   // High-water mark tracks level_d so it already includes the level of the next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hwm_q <= '0;
      end else if (flush) begin
         hwm_q <= '0;
      end else if (level_d > hwm_q) begin
         hwm_q <= level_d;
      end
   end

   // Saturating count of cycles where a push was offered but refused.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_cnt_q <= '0;
      end else if (bus.wr_valid && !bus.wr_ready && (ovf_cnt_q != 16'hFFFF)) begin
         ovf_cnt_q <= ovf_cnt_q + 16'd1;
      end
   end

   assign hwm     = hwm_q;
   assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_pdec_sp_fifo_ctrl.sv
// Self-checking bench for pdec_sp_fifo_ctrl with a behavioural SRAM (2-cycle read latency).
// A scoreboard queue receives every accepted push and is compared against every pop.
module tb_pdec_sp_fifo_ctrl;

   localparam int unsigned DW    = 16;
   localparam int unsigned AW    = 8;
   localparam int unsigned SD    = 2;
   localparam int unsigned NWORD = 256;
   localparam int unsigned LW    = AW + 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic [LW-1:0] level;
   logic          almost_full;
   logic          dpram_wen;
   logic [AW-1:0] dpram_waddr;
   logic [DW-1:0] dpram_wdata;
   logic          dpram_ren;
   logic [AW-1:0] dpram_raddr;
   logic [DW-1:0] dpram_rdata;
`ifdef PDEC_FIFO_STAT_EN
   logic [LW-1:0] hwm;
   logic [15:0]   ovf_cnt;
`endif

   pdec_sp_fifo_ctrl_if #(.DW(DW)) bus ();

   always #5 clk = ~clk;

   pdec_sp_fifo_ctrl #(
      .DW       (DW),
      .AW       (AW),
      .SRAM_DLY (SD),
      .AF_LVL   (240)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .bus         (bus),
      .level       (level),
      .almost_full (almost_full),
      .dpram_wen   (dpram_wen),
      .dpram_waddr (dpram_waddr),
      .dpram_wdata (dpram_wdata),
      .dpram_ren   (dpram_ren),
      .dpram_raddr (dpram_raddr),
      .dpram_rdata (dpram_rdata)
`ifdef PDEC_FIFO_STAT_EN
      ,
      .hwm         (hwm),
      .ovf_cnt     (ovf_cnt)
`endif
   );

   // Behavioural RAM: data for a read issued in cycle t is presented in cycle t+2.
   logic [DW-1:0] mem [NWORD];
   logic [DW-1:0] rpipe1, rpipe2;
   always @(posedge clk) begin
      if (dpram_wen) mem[dpram_waddr] <= dpram_wdata;
      rpipe1 <= dpram_ren ? mem[dpram_raddr] : 16'hDEAD;
      rpipe2 <= rpipe1;
   end
   assign dpram_rdata = rpipe2;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DW-1:0] sb[$];
   int pops = 0;
   int first_pop = -1;
   int last_pop = -1;
   int model_waddr = 0;
   int model_raddr = 0;
   int outst = 0;
   int wr_cyc[NWORD];
   int model_hwm = 0;
   int model_ovf = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor and scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         model_waddr = 0;
         model_raddr = 0;
         outst       = 0;
         model_hwm   = 0;
         model_ovf   = 0;
      end else begin
         check("level", int'(level), sb.size());
         check("almost_full", int'(almost_full), int'(sb.size() >= 240));
         check("credit_bound", int'(outst <= 3), 1);
`ifdef PDEC_FIFO_STAT_EN
         if (sb.size() > model_hwm) model_hwm = sb.size();
         check("hwm", int'(hwm), model_hwm);
         check("ovf_cnt", int'(ovf_cnt), model_ovf);
         if (bus.wr_valid && !bus.wr_ready && model_ovf < 65535) model_ovf++;
`endif
         check("wen", int'(dpram_wen), int'(bus.wr_valid && bus.wr_ready));
         if (dpram_wen) begin
            check("waddr", int'(dpram_waddr), model_waddr);
            check("wdata", int'(dpram_wdata), int'(bus.wr_data));
            wr_cyc[dpram_waddr] = cyc;
            model_waddr = (model_waddr + 1) % NWORD;
         end
         if (dpram_ren) begin
            check("raddr", int'(dpram_raddr), model_raddr);
            check("read_age", int'((cyc - wr_cyc[dpram_raddr]) >= 2), 1);
            model_raddr = (model_raddr + 1) % NWORD;
            outst++;
         end
         if (flush) begin
            sb.delete();
            model_waddr = 0;
            model_raddr = 0;
            outst       = 0;
            model_hwm   = 0;
         end else begin
            if (bus.rd_valid && bus.rd_ready) begin
               if (sb.size() == 0) check("pop_empty", 1, 0);
               else check("rd_data", int'(bus.rd_data), int'(sb.pop_front()));
               outst--;
               pops++;
               last_pop = cyc;
               if (first_pop < 0) first_pop = cyc;
            end
            if (bus.wr_valid && bus.wr_ready) sb.push_back(bus.wr_data);
         end
      end
   end

   task automatic producer(input int n, input int wgap);
      int  sent = 0;
      int  g = 0;
      bit  acc;
      while (sent < n && g < 20000) begin
         if (!bus.wr_valid && (wgap == 0 || $urandom_range(0, wgap) == 0)) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 16'($urandom);
         end
         @(negedge clk);
         acc = bus.wr_valid && bus.wr_ready;
         if (acc) sent++;
         step();
         if (acc) bus.wr_valid = 1'b0;
         g++;
      end
      bus.wr_valid = 1'b0;
      if (sent != n) check("producer_timeout", sent, n);
   endtask

   task automatic consumer(input int target, input int rmode);
      int g = 0;
      while (pops < target && g < 20000) begin
         case (rmode)
            0:       bus.rd_ready = 1'b1;
            1:       bus.rd_ready = 1'($urandom_range(0, 1));
            default: bus.rd_ready = !bus.rd_ready;
         endcase
         step();
         g++;
      end
      bus.rd_ready = 1'b0;
      check("consumer_timeout", pops, target);
   endtask

   typedef struct {
      logic          wv;
      logic [DW-1:0] wd;
      logic          exp_wen;
      logic          exp_ren;
      logic          exp_rv;
      logic [DW-1:0] exp_rd;
      int            exp_lvl;
   } vec_t;

   typedef struct {
      int n;
      int wgap;
      int rmode;
   } cfg_t;

   vec_t t1[7];
   cfg_t cfgs[3];

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int target, cnt, w;

      // Single-word latency: push at k=0 -> write k=0, read k=2, rd_valid k=5.
      t1[0] = '{1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000, 0};
      t1[1] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1};
      t1[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1};
      t1[3] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1};
      t1[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1};
      t1[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 1};
      t1[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 0};

      // Streams: back-to-back, random gaps with wrap, toggling backpressure.
      cfgs[0] = '{1000, 0, 0};
      cfgs[1] = '{600, 3, 1};
      cfgs[2] = '{300, 0, 2};

      rst_n = 1'b0;
      flush = 1'b0;
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
      bus.rd_ready = 1'b0;
      repeat (3) step();

      check("rst_wr_ready", int'(bus.wr_ready), 1);
      check("rst_rd_valid", int'(bus.rd_valid), 0);
      check("rst_rd_data", int'(bus.rd_data), 0);
      check("rst_level", int'(level), 0);
      check("rst_almost_full", int'(almost_full), 0);
      check("rst_wen", int'(dpram_wen), 0);
      check("rst_ren", int'(dpram_ren), 0);
      check("rst_waddr", int'(dpram_waddr), 0);
      check("rst_raddr", int'(dpram_raddr), 0);

      rst_n = 1'b1;
      repeat (3) step();

      // T1
      bus.rd_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         bus.wr_valid = t1[k].wv;
         bus.wr_data  = t1[k].wd;
         @(negedge clk);
         check($sformatf("t1_wen_%0d", k), int'(dpram_wen), int'(t1[k].exp_wen));
         check($sformatf("t1_ren_%0d", k), int'(dpram_ren), int'(t1[k].exp_ren));
         check($sformatf("t1_rv_%0d", k), int'(bus.rd_valid), int'(t1[k].exp_rv));
         check($sformatf("t1_lvl_%0d", k), int'(level), t1[k].exp_lvl);
         if (t1[k].exp_rv) check($sformatf("t1_rd_%0d", k), int'(bus.rd_data), int'(t1[k].exp_rd));
         step();
      end
      bus.rd_ready = 1'b0;

      // T2, T4, T6
      for (int c = 0; c < 3; c++) begin
         target    = pops + cfgs[c].n;
         first_pop = -1;
         fork
            producer(cfgs[c].n, cfgs[c].wgap);
            consumer(target, cfgs[c].rmode);
         join
         if (c == 0) check("t2_throughput", last_pop - first_pop + 1, cfgs[c].n);
         repeat (2) step();
         check($sformatf("stream_%0d_empty_level", c), int'(level), 0);
         check($sformatf("stream_%0d_rd_valid", c), int'(bus.rd_valid), 0);
      end

      // T3: fill with no reads; buffer prefetches OB words beyond the RAM depth.
      cnt = 0;
      bus.wr_valid = 1'b1;
      for (int i = 0; i < 400; i++) begin
         bus.wr_data = 16'(i * 7 + 3);
         @(negedge clk);
         if (!bus.wr_ready) break;
         cnt++;
         step();
      end
      check("t3_accepted", cnt, 259);
      repeat (4) step();
      @(negedge clk);
      check("t3_level", int'(level), 259);
      check("t3_almost_full", int'(almost_full), 1);
      check("t3_held", int'(bus.wr_ready), 0);
      step();
      bus.wr_valid = 1'b0;
      consumer(pops + 259, 0);

      // T5: flush with two reads in flight.
      repeat (2) step();
      bus.rd_ready = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_data  = 16'hA001;
      step();
      bus.wr_data  = 16'hA002;
      step();
      bus.wr_valid = 1'b0;
      step();
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      check("t5_level", int'(level), 0);
      check("t5_rd_valid", int'(bus.rd_valid), 0);
      for (int k = 0; k < 6; k++) begin
         step();
         check($sformatf("t5_stale_%0d", k), int'(bus.rd_valid), 0);
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = 16'hBEEF;
      step();
      bus.wr_valid = 1'b0;
      w = 0;
      while (!bus.rd_valid && w < 20) begin
         step();
         w++;
      end
      check("t5_beef_latency", w, 4);
      check("t5_beef_data", int'(bus.rd_data), 16'hBEEF);
      repeat (2) step();
      bus.rd_ready = 1'b0;

      // Asynchronous reset in the middle of traffic.
      bus.wr_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         bus.wr_data = 16'(16'h0C00 + k);
         step();
      end
      bus.wr_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_level", int'(level), 0);
      check("arst_rd_valid", int'(bus.rd_valid), 0);
      check("arst_wr_ready", int'(bus.wr_ready), 1);
      repeat (2) step();
      rst_n = 1'b1;
      step();
      bus.wr_valid = 1'b1;
      bus.wr_data  = 16'h55AA;
      step();
      bus.wr_valid = 1'b0;
      consumer(pops + 1, 0);
      repeat (2) step();
      check("arst_final_level", int'(level), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
